// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - FIFO-backed instruction/data sequencer with programmable NOP bubbles
module instr_feeder #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int GAP_W = 3
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_instr,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     run,
   input  logic [GAP_W-1:0]         gap,
   output logic [WIDTH-1:0]         i_datain,
   output logic [WIDTH-1:0]         d_datain,
   output logic                     issue_valid,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, PAD} state_t;

   state_t           state;
   state_t           state_next;
   logic             pop;
   logic             push;
   logic             can_pop;
   logic [GAP_W-1:0] pad_cnt;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [WIDTH-1:0] instr_mem [DEPTH];
   logic [WIDTH-1:0] data_mem  [DEPTH];

   assign push_ready = (level != FULL_LVL);
   assign push       = push_valid && push_ready;
   assign can_pop    = run && (level != '0);
   assign busy       = (state != IDLE);

   // pad_cnt holds the gap sampled at the last pop; PAD ends on the cycle it reads 1
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (can_pop) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (pad_cnt != '0) begin
               state_next = PAD;
            end else if (can_pop) begin
               pop        = 1'b1;
               state_next = ISSUE;
            end else begin
               state_next = IDLE;
            end
         end
         PAD: begin
            if (pad_cnt == GAP_W'(1)) begin
               if (can_pop) begin
                  pop        = 1'b1;
                  state_next = ISSUE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset && push) begin
         instr_mem[wr_ptr] <= push_instr;
         data_mem[wr_ptr]  <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         pad_cnt     <= '0;
         i_datain    <= '0;
         d_datain    <= '0;
         issue_valid <= 1'b0;
         done        <= 1'b0;
         count       <= '0;
      end else begin
         state <= state_next;
         done  <= (state != IDLE) && (state_next == IDLE) && (level == '0);
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            i_datain    <= instr_mem[rd_ptr];
            d_datain    <= data_mem[rd_ptr];
            issue_valid <= 1'b1;
            pad_cnt     <= gap;
            count       <= count + 16'd1;
         end else begin
            i_datain    <= '0;
            issue_valid <= 1'b0;
            if (state == PAD) begin
               pad_cnt <= pad_cnt - 1'b1;
            end
         end
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - vector table, corner sequences and randomized model check for instr_feeder
module tb_instr_feeder;

   localparam int DEPTH = 16;
   localparam logic [31:0] LW = 32'h8C01_0001;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        push_valid = 1'b0;
   logic        push_ready;
   logic [31:0] push_instr = '0;
   logic [31:0] push_data = '0;
   logic        run = 1'b0;
   logic [2:0]  gap = '0;
   logic [31:0] i_datain;
   logic [31:0] d_datain;
   logic        issue_valid;
   logic        busy;
   logic        done;
   logic [4:0]  level;
   logic [15:0] count;

   int vectors = 0;
   int miscompares = 0;

   instr_feeder #(.WIDTH(32), .DEPTH(DEPTH), .GAP_W(3)) dut (
      .clock(clock), .reset(reset),
      .push_valid(push_valid), .push_ready(push_ready),
      .push_instr(push_instr), .push_data(push_data),
      .run(run), .gap(gap),
      .i_datain(i_datain), .d_datain(d_datain),
      .issue_valid(issue_valid), .busy(busy), .done(done),
      .level(level), .count(count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic        pv;
      logic [31:0] pi;
      logic [31:0] pd;
      logic        rn;
      logic [2:0]  g;
      logic [31:0] ei;
      logic [31:0] ed;
      logic        eiv;
      logic        edone;
      logic        ebusy;
      logic        erdy;
      logic [4:0]  elvl;
      logic [15:0] ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] data;
   } entry_t;

   vec_t tbl[$];

   // model: a pop may happen once gap+1 edges have passed since the previous pop
   entry_t      mq[$];
   int          m_edge = 0;
   int          m_last = 0;
   int          m_gap = 0;
   bit          m_has = 0;
   logic [31:0] m_i = '0;
   logic [31:0] m_d = '0;
   bit          m_iv = 0;
   bit          m_done = 0;
   logic [15:0] m_cnt = '0;

   function automatic vec_t mk(logic rst, logic pv, logic [31:0] pi, logic [31:0] pd, logic rn,
                               logic [2:0] g, logic [31:0] ei, logic [31:0] ed, logic eiv,
                               logic edone, logic ebusy, logic erdy, logic [4:0] elvl,
                               logic [15:0] ecnt);
      vec_t v;
      v.rst = rst; v.pv = pv; v.pi = pi; v.pd = pd; v.rn = rn; v.g = g;
      v.ei = ei; v.ed = ed; v.eiv = eiv; v.edone = edone; v.ebusy = ebusy;
      v.erdy = erdy; v.elvl = elvl; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag, input logic [31:0] ei, input logic [31:0] ed,
                            input logic eiv, input logic edone, input logic ebusy,
                            input logic erdy, input logic [4:0] elvl, input logic [15:0] ecnt);
      check({tag, ".i_datain"}, i_datain, ei);
      check({tag, ".d_datain"}, d_datain, ed);
      check({tag, ".issue_valid"}, 32'(issue_valid), 32'(eiv));
      check({tag, ".done"}, 32'(done), 32'(edone));
      check({tag, ".busy"}, 32'(busy), 32'(ebusy));
      check({tag, ".push_ready"}, 32'(push_ready), 32'(erdy));
      check({tag, ".level"}, 32'(level), 32'(elvl));
      check({tag, ".count"}, 32'(count), 32'(ecnt));
   endtask

   task automatic step(input logic r, input logic pv, input logic [31:0] pi, input logic [31:0] pd,
                       input logic rn, input logic [2:0] g);
      reset = r; push_valid = pv; push_instr = pi; push_data = pd; run = rn; gap = g;
      @(negedge clock);
   endtask

   task automatic model_step(input logic r, input logic pv, input logic [31:0] pi,
                             input logic [31:0] pd, input logic rn, input logic [2:0] g);
      bit     do_pop;
      bit     do_push;
      bit     window_end;
      entry_t e;
      m_edge++;
      if (r) begin
         mq.delete();
         m_has = 0; m_i = '0; m_d = '0; m_iv = 0; m_done = 0; m_cnt = '0;
         return;
      end
      window_end = m_has && (m_edge == m_last + m_gap + 1);
      do_pop  = rn && (mq.size() > 0) && (!m_has || m_edge >= m_last + m_gap + 1);
      do_push = pv && (mq.size() < DEPTH);
      m_done  = !do_pop && window_end && (mq.size() == 0);
      if (do_pop) begin
         e = mq.pop_front();
         m_i = e.instr; m_d = e.data; m_iv = 1;
         m_cnt = m_cnt + 16'd1;
         m_last = m_edge; m_gap = int'(g); m_has = 1;
      end else begin
         m_i = '0; m_iv = 0;
      end
      if (do_push) begin
         e.instr = pi; e.data = pd;
         mq.push_back(e);
      end
   endtask

   initial begin
      // reset, single lw with gap 4, then a 3-deep back-to-back burst
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,1,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0,0,1,0,0));
      tbl.push_back(mk(0,1,LW,32'hab,1,4, 0,0,0,0,0,1,1,0));
      tbl.push_back(mk(0,0,0,0,1,4, LW,32'hab,1,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,4, 0,32'hab,0,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1, 0,32'hab,0,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1, 0,32'hab,0,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1, 0,32'hab,0,0,1,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1, 0,32'hab,0,1,0,1,0,1));
      tbl.push_back(mk(0,0,0,0,1,1, 0,32'hab,0,0,0,1,0,1));
      tbl.push_back(mk(0,1,32'h1111,32'hd1,0,0, 0,32'hab,0,0,0,1,1,1));
      tbl.push_back(mk(0,1,32'h2222,32'hd2,0,0, 0,32'hab,0,0,0,1,2,1));
      tbl.push_back(mk(0,1,32'h3333,32'hd3,0,0, 0,32'hab,0,0,0,1,3,1));
      tbl.push_back(mk(0,0,0,0,1,0, 32'h1111,32'hd1,1,0,1,1,2,2));
      tbl.push_back(mk(0,0,0,0,1,0, 32'h2222,32'hd2,1,0,1,1,1,3));
      tbl.push_back(mk(0,0,0,0,1,0, 32'h3333,32'hd3,1,0,1,1,0,4));
      tbl.push_back(mk(0,0,0,0,1,0, 0,32'hd3,0,1,0,1,0,4));
      tbl.push_back(mk(0,0,0,0,1,0, 0,32'hd3,0,0,0,1,0,4));

      foreach (tbl[k]) begin
         step(tbl[k].rst, tbl[k].pv, tbl[k].pi, tbl[k].pd, tbl[k].rn, tbl[k].g);
         check_all($sformatf("row%0d", k), tbl[k].ei, tbl[k].ed, tbl[k].eiv, tbl[k].edone,
                   tbl[k].ebusy, tbl[k].erdy, tbl[k].elvl, tbl[k].ecnt);
      end

      // fill to DEPTH with run low, overflow push, then concurrent push/pop at full
      for (int i = 0; i < DEPTH; i++) begin
         step(0, 1, 32'hF000_0000 + i, 32'hD000_0000 + i, 0, 0);
         check("fill.level", 32'(level), i + 1);
      end
      check("full.push_ready", 32'(push_ready), 0);
      step(0, 1, 32'hBAD0_0001, 32'h1, 0, 0);
      check("ovf.level", 32'(level), DEPTH);
      check("ovf.push_ready", 32'(push_ready), 0);
      check("ovf.issue_valid", 32'(issue_valid), 0);
      step(0, 1, 32'hBAD0_0002, 32'h2, 1, 0);
      check("fullpp.level", 32'(level), DEPTH - 1);
      check("fullpp.i_datain", i_datain, 32'hF000_0000);
      for (int i = 1; i < DEPTH; i++) begin
         step(0, 0, 0, 0, 1, 0);
         check("stream.i_datain", i_datain, 32'hF000_0000 + i);
         check("stream.d_datain", d_datain, 32'hD000_0000 + i);
         check("stream.level", 32'(level), DEPTH - 1 - i);
      end
      step(0, 0, 0, 0, 1, 0);
      check("drain.done", 32'(done), 1);
      check("drain.issue_valid", 32'(issue_valid), 0);
      check("drain.i_datain", i_datain, 0);
      check("drain.count", 32'(count), 20);

      // concurrent push and pop at level 5
      for (int i = 0; i < 5; i++) step(0, 1, 32'hA000_0000 + i, 32'hB000_0000 + i, 0, 0);
      check("l5.level", 32'(level), 5);
      step(0, 1, 32'hC000_0000, 32'hC1, 1, 0);
      check("l5pp0.level", 32'(level), 5);
      check("l5pp0.i_datain", i_datain, 32'hA000_0000);
      step(0, 1, 32'hC000_0001, 32'hC2, 1, 0);
      check("l5pp1.level", 32'(level), 5);
      check("l5pp1.i_datain", i_datain, 32'hA000_0001);
      step(0, 0, 0, 0, 0, 0);
      check("l5stop.busy", 32'(busy), 0);
      check("l5stop.done", 32'(done), 0);
      check("l5stop.level", 32'(level), 5);

      // run dropped during a 3-cycle pad; gap changes mid-pad must not stretch it
      step(0, 0, 0, 0, 1, 3);
      check("drop.i_datain", i_datain, 32'hA000_0002);
      check("drop.level", 32'(level), 4);
      step(0, 0, 0, 0, 1, 0);
      check("drop.pad1.busy", 32'(busy), 1);
      check("drop.pad1.iv", 32'(issue_valid), 0);
      step(0, 0, 0, 0, 0, 7);
      check("drop.pad2.busy", 32'(busy), 1);
      step(0, 0, 0, 0, 0, 7);
      check("drop.pad3.busy", 32'(busy), 1);
      check("drop.pad3.iv", 32'(issue_valid), 0);
      step(0, 0, 0, 0, 0, 0);
      check("drop.idle.busy", 32'(busy), 0);
      check("drop.idle.done", 32'(done), 0);
      check("drop.idle.iv", 32'(issue_valid), 0);
      check("drop.idle.level", 32'(level), 4);

      // reset mid-stream, with a push and run on the same edge
      step(0, 0, 0, 0, 1, 0);
      check("pre_rst.i_datain", i_datain, 32'hA000_0003);
      check("pre_rst.count", 32'(count), 24);
      step(1, 1, 32'h5555_5555, 32'h55, 1, 0);
      check_all("midrst", 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check_all("postrst", 0, 0, 0, 0, 0, 1, 0, 0);

      // randomized phase against the model
      step(1, 0, 0, 0, 0, 0);
      model_step(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 3000; k++) begin
         logic        r, pv, rn;
         logic [31:0] pi, pd;
         logic [2:0]  g;
         int          ph, pp, rp;
         ph = (k / 300) % 3;
         pp = (ph == 0) ? 60 : (ph == 1) ? 95 : 25;
         rp = (ph == 1) ? 20 : 85;
         r  = ($urandom_range(0, 999) == 0);
         pv = ($urandom_range(0, 99) < pp);
         rn = ($urandom_range(0, 99) < rp);
         pi = $urandom;
         pd = $urandom;
         g  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 1));
         step(r, pv, pi, pd, rn, g);
         model_step(r, pv, pi, pd, rn, g);
         check_all("rand", m_i, m_d, m_iv, m_done,
                   m_has && ((m_edge - m_last) <= m_gap),
                   mq.size() < DEPTH, 5'(mq.size()), m_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/instr_feeder.md
# instr_feeder

Parametrised instruction/data stimulus sequencer for the pipelined MIPS CPU. It buffers instruction words and companion load-data words in a FIFO and drives `i_datain` and `d_datain` of `CPU` once per clock. After every issued instruction it inserts a programmable number of NOP bubbles, replacing hand-written NOP padding between instructions. It also reports completion and issue count.

## Interface
- `WIDTH`, default 32: instruction and data word width.
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `GAP_W`, default 3: width of the bubble-count input.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `push_valid` in 1: a write entry is offered.
- `push_ready` out 1: FIFO can accept an entry; equals `!full`, combinational from registered level.
- `push_instr` in WIDTH: instruction word to enqueue.
- `push_data` in WIDTH: data word to present on `d_datain` with that instruction.
- `run` in 1: issue enable.
- `gap` in GAP_W: number of NOP cycles after each issued instruction; sampled at issue.
- `i_datain` out WIDTH: instruction to the CPU; all zeros (NOP) when not issuing.
- `d_datain` out WIDTH: data to the CPU; holds the last issued entry's data.
- `issue_valid` out 1: high for the cycle `i_datain` carries a real instruction.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the queue drains.
- `level` out log2(DEPTH)+1: FIFO occupancy.
- `count` out 16: number of instructions issued since reset.

## Operation
- **FIFO:**
  - Circular buffer with read and write pointers of log2(DEPTH) bits; pointers wrap modulo DEPTH.
  - A push is accepted when `push_valid && push_ready`.
  - No bypass: a pushed entry can be issued at the earliest on the following edge.
  - Push and pop on the same edge is legal; `level` is unchanged.
  - A push while full is ignored; FIFO contents and `level` are unchanged.
- **FSM states:**
  - **IDLE:**
    - If `run && level != 0`: pop the head, go to ISSUE.
    - Otherwise stay in IDLE.
  - **ISSUE** (the instruction is on the outputs this cycle):
    - If the sampled gap is greater than 0, go to PAD.
    - Else if `run && level != 0`, pop again and stay in ISSUE.
    - Else go to IDLE.
  - **PAD:**
    - `pad_cnt` decrements each cycle.
    - When `pad_cnt == 1`, behave as ISSUE's gap-0 branch: pop if `run && level != 0`, otherwise go to IDLE.
- **On a pop edge:**
  - `i_datain <= instr`, `d_datain <= data`, `issue_valid <= 1`, `pad_cnt <= gap`, `count <= count + 1`.
  - `count` wraps from 0xFFFF to 0.
- **On non-pop edges:** `i_datain <= 0` and `issue_valid <= 0`; `d_datain` holds.
- **`done`:** pulses for one cycle on the edge that enters IDLE from ISSUE or PAD while `level == 0`.
- **`run` deasserted mid-stream:** the current pad completes, no further pop occurs, the FSM returns to IDLE, and no `done` pulse is produced if `level > 0`.

## Timing
- **Reset values:**
  - FIFO emptied; `level = 0`, `push_ready = 1`, state IDLE.
  - `i_datain = 0`, `d_datain = 0`, `issue_valid = 0`, `busy = 0`, `done = 0`, `count = 0`.
- **Reset priority:** reset asserted mid-operation overrides every other input on that edge, including a push.
- **Issue latency:** entry pushed at edge N with `run` high and the FSM idle appears on `i_datain` after edge N+1.
- **Issue spacing:** consecutive instructions are `gap + 1` cycles apart. With `gap = 0`, a full FIFO streams one instruction per cycle.
- **Gap sampling:** `gap` is sampled only on pop edges; changing it during PAD does not affect the current pad.

## Test plan
- **Reset values:** assert `reset` for 2 cycles -> every output at its reset value and `push_ready = 1`.
- **Single lw with gap 4:**
  - Stimulus: push `{100011, gr0, gr1, 0x0001}` with data 0x000000ab, `gap = 4`, `run = 1`.
  - Required: `i_datain` = instr for 1 cycle then 0 for 4 cycles; `d_datain` = 0xab throughout; `count = 1`; `done` pulses once, one cycle after the last NOP.
- **Back-to-back stream:** push 3 entries, `gap = 0` -> 3 consecutive `issue_valid` cycles in push order; `level` goes 3→2→1→0; single `done` pulse.
- **Full FIFO:**
  - Stimulus: `run = 0`, push DEPTH entries.
  - Required: `push_ready = 0` and `level = 16`; a 17th push is ignored.
  - Then `run = 1`: all 16 entries issue in order, pointers wrap correctly.
- **Concurrent push and pop:** push concurrent with a pop while at `level = 16` -> `push_ready = 0`, push rejected. Push concurrent with a pop at `level = 5` -> `level` stays 5.
- **`run` drop and mid-stream reset:**
  - Drop `run` during PAD -> the pad finishes, FSM goes to IDLE with no pop and no `done`.
  - Assert `reset` mid-stream -> the next cycle shows reset values and `count = 0`.
